// File: rtl/ex_stack_pkg.sv
// Shared definitions for the expression stack and its sequencer:
// ex_stack op codes, request opcodes, FSM states and the legality check.
package ex_stack_pkg;

    localparam int ES_DEPTH = 32;
    localparam int ES_WIDTH = 16;

    // ex_stack native operations
    localparam logic [1:0] ES_PUSH = 2'd0;
    localparam logic [1:0] ES_POP  = 2'd1;
    localparam logic [1:0] ES_DUP  = 2'd2;

    // control-unit request opcodes (5..7 are illegal)
    localparam logic [2:0] REQ_PUSH = 3'd0;
    localparam logic [2:0] REQ_POP1 = 3'd1;
    localparam logic [2:0] REQ_POP2 = 3'd2;
    localparam logic [2:0] REQ_DUP  = 3'd3;
    localparam logic [2:0] REQ_SWAP = 3'd4;

    typedef enum logic [2:0] {
        IDLE, EXEC, SW_POP, SW_PUSHA, SW_PUSHB, SETTLE
    } ctrlState_e;

    typedef enum logic [1:0] {
        CHK_OK, CHK_OVF, CHK_UNF, CHK_ILL
    } chkRes_e;

    // Legality of a request against the occupancy before it executes.
    // For DUP an underflow wins over an overflow.
    function automatic chkRes_e checkReq(input logic [2:0] op, input logic [1:0] dupN,
                                         input int unsigned depth, input int unsigned maxDepth);
        chkRes_e r;
        int unsigned k;
        k = 32'(dupN) + 32'd1;
        case (op)
            REQ_PUSH: r = (depth < maxDepth) ? CHK_OK : CHK_OVF;
            REQ_POP1: r = (depth >= 32'd1) ? CHK_OK : CHK_UNF;
            REQ_POP2,
            REQ_SWAP: r = (depth >= 32'd2) ? CHK_OK : CHK_UNF;
            REQ_DUP: begin
                if (depth < k)                 r = CHK_UNF;
                else if (depth + k > maxDepth) r = CHK_OVF;
                else                           r = CHK_OK;
            end
            default:  r = CHK_ILL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_stack.sv
// 16-bit expression stack: push, pop one/two, dup top 1..4 entries.
// Out-of-range operations are silently ignored; outA/outB show TOS/next.
module ex_stack
    import ex_stack_pkg::*;
#(
    parameter int DEPTH = ES_DEPTH,
    parameter int WIDTH = ES_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ESAct,
    input  logic [1:0]       ESOp,
    input  logic             popNum,
    input  logic [1:0]       dupNum,
    input  logic [WIDTH-1:0] pushVal,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB
);
    localparam int PW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [2**PW];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    k;
    logic             pushOk, dupOk;

    assign k      = PW'(dupNum) + PW'(1);
    assign pushOk = ESAct && (ESOp == ES_PUSH) && (sp < PW'(DEPTH));
    assign dupOk  = ESAct && (ESOp == ES_DUP) && (sp >= k) && (sp + k <= PW'(DEPTH));
    assign outA   = (sp >= PW'(1)) ? mem[sp - PW'(1)] : '0;
    assign outB   = (sp >= PW'(2)) ? mem[sp - PW'(2)] : '0;

    // stack pointer; reset discards whatever the array still holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (pushOk) begin
            sp <= sp + PW'(1);
        end else if (dupOk) begin
            sp <= sp + k;
        end else if (ESAct && ESOp == ES_POP) begin
            if (popNum && sp >= PW'(2))       sp <= sp - PW'(2);
            else if (!popNum && sp >= PW'(1)) sp <= sp - PW'(1);
        end
    end

    // entry storage: push writes the free slot, dup copies the top k upward
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[sp] <= pushVal;
        end else if (dupOk) begin
            for (int i = 0; i < 4; i++)
                if (PW'(i) < k) mem[sp + PW'(i)] <= mem[sp - k + PW'(i)];
        end
    end

endmodule

// File: rtl/ex_stack_ctrl.sv
// Sequencer between the control unit and ex_stack. Tracks occupancy,
// rejects illegal requests with error pulses, and expands SWAP into
// pop-two / push-old-top / push-old-next.
module ex_stack_ctrl
    import ex_stack_pkg::*;
#(
    parameter int DEPTH = ES_DEPTH,
    parameter int WIDTH = ES_WIDTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [2:0]       reqOp,
    input  logic [1:0]       reqDupNum,
    input  logic [WIDTH-1:0] reqVal,
    input  logic [WIDTH-1:0] stkA,
    input  logic [WIDTH-1:0] stkB,
    output logic             ESAct,
    output logic [1:0]       ESOp,
    output logic             popNum,
    output logic [1:0]       dupNum,
    output logic [WIDTH-1:0] pushVal,
    output logic [CW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             done,
    output logic             errOverflow,
    output logic             errUnderflow,
    output logic             errIllegal,
    output logic             errSticky
);
    ctrlState_e       state, nextState;
    chkRes_e          reqChk;
    logic [2:0]       opQ;
    logic [1:0]       dupQ;
    logic [WIDTH-1:0] valQ, swA, swB;
    logic [CW-1:0]    depthQ;
    logic             readyEn, accept, reject;

    // readyEn keeps reqReady low until the first clock after reset release;
    // a pending done/error pulse also holds it low for that cycle
    assign reqReady = readyEn && (state == IDLE) && !done;
    assign accept   = reqValid && reqReady;
    assign reqChk   = checkReq(reqOp, reqDupNum, 32'(depthQ), 32'(DEPTH));
    assign reject   = accept && (reqChk != CHK_OK);

    assign depth = depthQ;
    assign full  = (depthQ == CW'(DEPTH));
    assign empty = (depthQ == '0);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // next-state: rejected requests never leave IDLE
    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (accept && reqChk == CHK_OK)
                          nextState = (reqOp == REQ_SWAP) ? SW_POP : EXEC;
            EXEC:     nextState = SETTLE;
            SW_POP:   nextState = SW_PUSHA;
            SW_PUSHA: nextState = SW_PUSHB;
            SW_PUSHB: nextState = SETTLE;
            SETTLE:   nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // ex_stack drive: everything is zero outside the strobe cycle
    always_comb begin
        ESAct   = 1'b0;
        ESOp    = ES_PUSH;
        popNum  = 1'b0;
        dupNum  = 2'd0;
        pushVal = '0;
        case (state)
            EXEC: begin
                ESAct = 1'b1;
                case (opQ)
                    REQ_PUSH: pushVal = valQ;
                    REQ_POP1: ESOp = ES_POP;
                    REQ_POP2: begin ESOp = ES_POP; popNum = 1'b1; end
                    REQ_DUP:  begin ESOp = ES_DUP; dupNum = dupQ; end
                    default:  ESAct = 1'b0;
                endcase
            end
            SW_POP:   begin ESAct = 1'b1; ESOp = ES_POP; popNum = 1'b1; end
            SW_PUSHA: begin ESAct = 1'b1; pushVal = swA; end
            SW_PUSHB: begin ESAct = 1'b1; pushVal = swB; end
            default:  ;
        endcase
    end

    // request capture; SWAP operands come from the settled stack outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ  <= '0;
            dupQ <= '0;
            valQ <= '0;
            swA  <= '0;
            swB  <= '0;
        end else if (accept) begin
            opQ  <= reqOp;
            dupQ <= reqDupNum;
            valQ <= reqVal;
            swA  <= stkA;
            swB  <= stkB;
        end
    end

    // occupancy follows exactly what is strobed into ex_stack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depthQ <= '0;
        end else if (ESAct) begin
            case (ESOp)
                ES_PUSH: depthQ <= depthQ + CW'(1);
                ES_POP:  depthQ <= depthQ - (popNum ? CW'(2) : CW'(1));
                ES_DUP:  depthQ <= depthQ + CW'(dupNum) + CW'(1);
                default: ;
            endcase
        end
    end

    // registered retire/error pulses and the sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readyEn      <= 1'b0;
            done         <= 1'b0;
            errOverflow  <= 1'b0;
            errUnderflow <= 1'b0;
            errIllegal   <= 1'b0;
            errSticky    <= 1'b0;
        end else begin
            readyEn      <= 1'b1;
            done         <= (nextState == SETTLE) || reject;
            errOverflow  <= accept && (reqChk == CHK_OVF);
            errUnderflow <= accept && (reqChk == CHK_UNF);
            errIllegal   <= accept && (reqChk == CHK_ILL);
            errSticky    <= errSticky || reject;
        end
    end

endmodule

// File: tb/tb_ex_stack_ctrl.sv
// Bench for ex_stack_ctrl driving a real ex_stack. A queue-based stack model
// predicts per-cycle outputs of every request; one compare process checks them.
module tb_ex_stack_ctrl;
    import ex_stack_pkg::*;

    localparam int D = 32;
    localparam int W = 16;
    localparam int C = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         reqValid = 1'b0;
    logic         reqReady;
    logic [2:0]   reqOp = 3'd0;
    logic [1:0]   reqDupNum = 2'd0;
    logic [W-1:0] reqVal = '0;
    logic [W-1:0] stkA, stkB, pushVal;
    logic         ESAct, popNum;
    logic [1:0]   ESOp, dupNum;
    logic [C-1:0] depth;
    logic         full, empty, done, errOverflow, errUnderflow, errIllegal, errSticky;

    always #5 clk = ~clk;

    ex_stack_ctrl #(.DEPTH(D), .WIDTH(W), .CW(C)) dut (
        .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
        .reqOp(reqOp), .reqDupNum(reqDupNum), .reqVal(reqVal),
        .stkA(stkA), .stkB(stkB), .ESAct(ESAct), .ESOp(ESOp), .popNum(popNum),
        .dupNum(dupNum), .pushVal(pushVal), .depth(depth), .full(full), .empty(empty),
        .done(done), .errOverflow(errOverflow), .errUnderflow(errUnderflow),
        .errIllegal(errIllegal), .errSticky(errSticky)
    );

    ex_stack #(.DEPTH(D), .WIDTH(W)) stk (
        .clk(clk), .rst_n(rst_n), .ESAct(ESAct), .ESOp(ESOp), .popNum(popNum),
        .dupNum(dupNum), .pushVal(pushVal), .outA(stkA), .outB(stkB)
    );

    typedef struct {
        int ready, act, op, pn, dn, pv, done, eo, eu, ei, sticky, depth, nTop, top, nxt;
    } expT;

    expT expQ[$];
    expT cur;
    int  mdl[$];
    int  mSticky = 0;
    int  checks = 0;
    int  failures = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic expT idleE(input int d);
        expT e;
        e.ready = 0; e.act = 0; e.op = 0; e.pn = 0; e.dn = 0; e.pv = 0;
        e.done = 0; e.eo = 0; e.eu = 0; e.ei = 0; e.sticky = mSticky;
        e.depth = d; e.nTop = 0; e.top = 0; e.nxt = 0;
        return e;
    endfunction

    function automatic expT withTops(input expT e);
        expT r = e;
        r.nTop = mdl.size();
        if (r.nTop >= 1) r.top = mdl[$];
        if (r.nTop >= 2) r.nxt = mdl[$-1];
        return r;
    endfunction

    // compare process: one expected record per cycle while a request is in flight
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            chk("reqReady", 32'(reqReady), cur.ready);
            chk("ESAct", 32'(ESAct), cur.act);
            chk("ESOp", 32'(ESOp), cur.op);
            chk("popNum", 32'(popNum), cur.pn);
            chk("dupNum", 32'(dupNum), cur.dn);
            chk("pushVal", 32'(pushVal), cur.pv);
            chk("done", 32'(done), cur.done);
            chk("errOverflow", 32'(errOverflow), cur.eo);
            chk("errUnderflow", 32'(errUnderflow), cur.eu);
            chk("errIllegal", 32'(errIllegal), cur.ei);
            chk("errSticky", 32'(errSticky), cur.sticky);
            chk("depth", 32'(depth), cur.depth);
            chk("full", 32'(full), (cur.depth == D) ? 1 : 0);
            chk("empty", 32'(empty), (cur.depth == 0) ? 1 : 0);
            if (cur.nTop >= 1) chk("stkA", 32'(stkA), cur.top);
            if (cur.nTop >= 2) chk("stkB", 32'(stkB), cur.nxt);
        end
    end

    // issue one request at posedge+1 of its accept cycle; returns at the next ready cycle
    task automatic doReq(input logic [2:0] op, input logic [1:0] dn, input logic [W-1:0] val);
        int  d0, k, kind, nCyc, a, b;
        int  dupTmp[$];
        expT e;
        d0 = mdl.size();
        k  = int'(dn) + 1;
        case (op)
            3'd0:    kind = (d0 < D) ? 0 : 1;
            3'd1:    kind = (d0 >= 1) ? 0 : 2;
            3'd2:    kind = (d0 >= 2) ? 0 : 2;
            3'd3:    kind = (d0 < k) ? 2 : ((d0 + k > D) ? 1 : 0);
            3'd4:    kind = (d0 >= 2) ? 0 : 2;
            default: kind = 3;
        endcase
        reqValid = 1'b1; reqOp = op; reqDupNum = dn; reqVal = val;
        e = idleE(d0); e.ready = 1; expQ.push_back(e);
        if (kind != 0) begin
            mSticky = 1;
            e = idleE(d0); e.done = 1;
            e.eo = (kind == 1) ? 1 : 0; e.eu = (kind == 2) ? 1 : 0; e.ei = (kind == 3) ? 1 : 0;
            expQ.push_back(withTops(e));
            nCyc = 2;
        end else if (op == 3'd4) begin
            a = mdl[$]; b = mdl[$-1];
            e = idleE(d0);     e.act = 1; e.op = 1; e.pn = 1; expQ.push_back(e);
            e = idleE(d0 - 2); e.act = 1; e.pv = a;           expQ.push_back(e);
            e = idleE(d0 - 1); e.act = 1; e.pv = b;           expQ.push_back(e);
            void'(mdl.pop_back()); void'(mdl.pop_back());
            mdl.push_back(a); mdl.push_back(b);
            e = idleE(d0); e.done = 1; expQ.push_back(withTops(e));
            nCyc = 5;
        end else begin
            e = idleE(d0); e.act = 1;
            case (op)
                3'd0:    e.pv = int'(val);
                3'd1:    e.op = 1;
                3'd2:    begin e.op = 1; e.pn = 1; end
                default: begin e.op = 2; e.dn = int'(dn); end
            endcase
            expQ.push_back(e);
            case (op)
                3'd0:    mdl.push_back(int'(val));
                3'd1:    void'(mdl.pop_back());
                3'd2:    begin void'(mdl.pop_back()); void'(mdl.pop_back()); end
                default: begin
                    for (int i = 0; i < k; i++) dupTmp.push_back(mdl[d0 - k + i]);
                    foreach (dupTmp[i]) mdl.push_back(dupTmp[i]);
                end
            endcase
            e = idleE(mdl.size()); e.done = 1; expQ.push_back(withTops(e));
            nCyc = 3;
        end
        @(posedge clk); #1;
        reqValid = 1'b0; reqOp = 3'd0; reqDupNum = 2'd0; reqVal = 16'hDEAD;
        repeat (nCyc - 1) begin @(posedge clk); #1; end
    endtask

    task automatic doReset();
        expQ.delete();
        rst_n = 1'b0; #1;
        chk("rst_ESAct", 32'(ESAct), 0);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_errs", 32'({errOverflow, errUnderflow, errIllegal}), 0);
        chk("rst_errSticky", 32'(errSticky), 0);
        mdl.delete(); mSticky = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_reqReady", 32'(reqReady), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        #2;
        doReset();
        chk("init_empty", 32'(empty), 1);

        // single push / pop
        doReq(REQ_PUSH, 2'd0, 16'h0001);
        chk("lit_push_top", 32'(stkA), 1);
        chk("lit_push_depth", 32'(depth), 1);
        doReq(REQ_POP1, 2'd0, 16'h0);
        chk("lit_pop_empty", 32'(empty), 1);
        chk("lit_pop_sticky", 32'(errSticky), 0);

        // fill to capacity, then overflow
        for (int i = 1; i <= 32; i++) doReq(REQ_PUSH, 2'd0, 16'(i));
        chk("lit_full", 32'(full), 1);
        chk("lit_depth32", 32'(depth), 32);
        doReq(REQ_PUSH, 2'd0, 16'd33);
        chk("lit_ovf_top", 32'(stkA), 32);
        chk("lit_ovf_sticky", 32'(errSticky), 1);
        doReq(REQ_DUP, 2'd0, 16'h0);

        // POP2 then DUP of two back to full
        doReq(REQ_POP2, 2'd0, 16'h0);
        chk("lit_pop2_depth", 32'(depth), 30);
        chk("lit_pop2_a", 32'(stkA), 30);
        chk("lit_pop2_b", 32'(stkB), 29);
        doReq(REQ_DUP, 2'd1, 16'h0);
        chk("lit_dup_depth", 32'(depth), 32);
        chk("lit_dup_a", 32'(stkA), 30);
        chk("lit_dup_b", 32'(stkB), 29);
        chk("mdl_top0", 32'(mdl[31]), 30);
        chk("mdl_top1", 32'(mdl[30]), 29);
        chk("mdl_top2", 32'(mdl[29]), 30);
        chk("mdl_top3", 32'(mdl[28]), 29);
        doReq(REQ_POP2, 2'd0, 16'h0);
        chk("lit_dup_c", 32'(stkA), 30);
        chk("lit_dup_d", 32'(stkB), 29);

        // SWAP on [..,5,7]
        doReset();
        doReq(REQ_PUSH, 2'd0, 16'd5);
        doReq(REQ_PUSH, 2'd0, 16'd7);
        doReq(REQ_SWAP, 2'd0, 16'h0);
        chk("lit_swap_a", 32'(stkA), 5);
        chk("lit_swap_b", 32'(stkB), 7);
        chk("lit_swap_depth", 32'(depth), 2);
        doReq(REQ_POP2, 2'd0, 16'h0);

        // errors on an empty stack
        doReq(REQ_POP1, 2'd0, 16'h0);
        doReq(REQ_DUP, 2'd0, 16'h0);
        doReq(3'd6, 2'd0, 16'h0);
        chk("lit_err_sticky", 32'(errSticky), 1);
        chk("lit_err_depth", 32'(depth), 0);

        // reset in the middle of a SWAP
        doReq(REQ_PUSH, 2'd0, 16'd1);
        doReq(REQ_PUSH, 2'd0, 16'd2);
        doReq(REQ_PUSH, 2'd0, 16'd3);
        reqValid = 1'b1; reqOp = REQ_SWAP;
        @(posedge clk); #1;
        reqValid = 1'b0; reqOp = 3'd0;
        chk("sw_n1_act", 32'(ESAct), 1);
        chk("sw_n1_op", 32'(ESOp), 1);
        chk("sw_n1_pop", 32'(popNum), 1);
        @(posedge clk); #1;
        chk("sw_n2_act", 32'(ESAct), 1);
        chk("sw_n2_pv", 32'(pushVal), 3);
        chk("sw_n2_depth", 32'(depth), 1);
        chk("sw_n2_sticky", 32'(errSticky), 1);
        doReset();
        doReq(REQ_PUSH, 2'd0, 16'h00AA);
        chk("lit_post_rst_top", 32'(stkA), 32'h00AA);
        chk("lit_post_rst_depth", 32'(depth), 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stack_ctrl.md
Name: ex_stack_ctrl

Overview:
- Sequencer between the control unit and the 16-bit expression stack (ex_stack). Accepts one stack request at a time over a valid/ready handshake.
- Checks each request against a tracked occupancy count, then drives ex_stack's ESAct/ESOp/popNum/dupNum/pushVal.
- Expands SWAP into a three-operation sequence, since ex_stack has no native SWAP.
- Reports overflow, underflow and illegal-op errors instead of letting ex_stack silently ignore them.

Parameters:
- DEPTH, 32, number of ex_stack entries.
- WIDTH, 16, data width.
- CW, 6, width of the depth counter, equal to clog2(DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- reqValid  in  1  request present.
- reqReady  out  1  controller can accept a request.
- reqOp  in  3  request opcode: 0 PUSH, 1 POP1, 2 POP2, 3 DUP, 4 SWAP; 5-7 are illegal.
- reqDupNum  in  2  DUP count minus one; DUP copies the top reqDupNum+1 entries.
- reqVal  in  WIDTH  value for PUSH.
- stkA  in  WIDTH  ex_stack outA (top of stack).
- stkB  in  WIDTH  ex_stack outB (next entry).
- ESAct  out  1  ex_stack action strobe.
- ESOp  out  2  ex_stack op: 0 push, 1 pop, 2 dup.
- popNum  out  1  0 pops one entry, 1 pops two.
- dupNum  out  2  passed through to ex_stack.
- pushVal  out  WIDTH  value to push.
- depth  out  CW  current occupancy, 0..DEPTH.
- full  out  1  depth==DEPTH.
- empty  out  1  depth==0.
- done  out  1  one-cycle pulse when a request retires.
- errOverflow  out  1  one-cycle pulse.
- errUnderflow  out  1  one-cycle pulse.
- errIllegal  out  1  one-cycle pulse.
- errSticky  out  1  OR of all error pulses; cleared only by reset.

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - State returns to IDLE and depth becomes 0.
  - ESAct, ESOp, popNum, dupNum, pushVal, done, all error outputs and errSticky go to 0.
  - reqReady goes to 1 on the first clock after deassertion.
  - Reset mid-sequence abandons the sequence. ESAct drops immediately. Stale ex_stack contents are treated as empty.
- States: IDLE, EXEC, SW_POP, SW_PUSHA, SW_PUSHB, SETTLE.
- Handshake:
  - reqReady=1 only in IDLE.
  - A request is accepted on a clock edge where reqValid&reqReady. reqOp, reqDupNum and reqVal are registered at that edge.
  - reqVal may change after acceptance.
- Legality is checked at accept, against depth before the operation:
  - PUSH: depth<DEPTH, otherwise overflow.
  - POP1: depth>=1, otherwise underflow.
  - POP2: depth>=2, otherwise underflow.
  - DUP with k=reqDupNum+1: depth>=k, otherwise underflow. If that passes, depth+k<=DEPTH, otherwise overflow. Underflow takes priority.
  - SWAP: depth>=2, otherwise underflow.
  - Opcodes 5-7: illegal.
- Illegal or failing request:
  - State stays IDLE and ESAct is never asserted.
  - In the cycle after accept: the matching error pulse and done both pulse, and errSticky sets.
  - depth is unchanged.
- Legal primitive, accept at cycle N:
  - EXEC at N+1: ESAct=1 with ESOp/popNum/dupNum/pushVal driven, and depth updated at the end of N+1.
  - SETTLE at N+2: ESAct=0, done=1.
  - IDLE (reqReady=1) at N+3.
- SWAP, accept at cycle N:
  - At the accept edge, latch a=stkA and b=stkB. Both are stable because ex_stack has settled in IDLE.
  - SW_POP at N+1: ESOp=1, popNum=1.
  - SW_PUSHA at N+2: push a.
  - SW_PUSHB at N+3: push b.
  - SETTLE at N+4: done=1.
  - Result: top of stack is old B, next entry is old A. Net depth change is 0, but depth steps -2, +1, +1 across the sequence.
- Depth arithmetic:
  - PUSH +1, POP1 -1, POP2 -2, DUP +k.
  - Saturation never triggers because illegal ops are blocked beforehand.
- Outputs: ESOp, popNum, dupNum and pushVal are 0 in every state except the one where ESAct=1.
- Output timing: done and the error pulses are registered, and none are ever asserted together with reqReady.

Decomposition:
- Shared package ex_stack_pkg holds:
  - ex_stack op codes ES_PUSH=0, ES_POP=1, ES_DUP=2.
  - Request opcodes REQ_PUSH..REQ_SWAP.
  - The state enum.
  - DEPTH and WIDTH defaults.
- Single module. The legality check is a combinational function in the package; no sub-module is needed.
- The bench instantiates ex_stack_ctrl together with a real ex_stack so stkA/stkB are genuine.

Test Plan:
- Reset, then PUSH 0x0001, then POP1.
  - PUSH: ESAct exactly one cycle, depth 0->1, stkA=1, done at N+2.
  - POP1: depth 1->0, empty=1, no error.
- 32 PUSHes of values 1..32, then a 33rd PUSH of 33.
  - After the 32nd: full=1, depth=32.
  - 33rd: errOverflow pulses one cycle, ESAct stays 0, stkA stays 32, errSticky=1.
- From depth 32, POP2 then DUP with reqDupNum=1.
  - POP2: depth 30, stkA=30, stkB=29.
  - DUP: depth 32, the top four entries read 30,29,30,29.
- Stack holding [..,5,7] (TOS 7), then SWAP.
  - ESAct high for cycles N+1..N+3 with ESOp sequence 1,0,0 and pushVal 7 then 5.
  - Result stkA=5, stkB=7, depth unchanged, done at N+4.
- Empty stack: POP1, then DUP with reqDupNum=0, then reqOp=6.
  - POP1 and DUP: errUnderflow pulses.
  - reqOp=6: errIllegal pulses.
  - Each retires in 1 cycle with no ESAct.
- rst_n asserted low at cycle N+2 of a SWAP.
  - ESAct drops asynchronously, depth=0, all error outputs 0.
  - reqReady=1 on the first clock after release.
